// File: rtl/sha256d_nonce_scanner_if.sv
// Word-request and control bus between the nonce scanner (master) and one sha256d_wrapper core (slave).
interface sha256d_nonce_scanner_if;
  logic         core_rst_n;
  logic         core_start;
  logic [4:0]   core_addr;
  logic         core_rq;
  logic         core_rdy;
  logic [31:0]  core_data;
  logic [255:0] core_hash;
  logic         core_done;

  modport master (
    output core_rst_n,
    output core_start,
    input  core_addr,
    input  core_rq,
    output core_rdy,
    output core_data,
    input  core_hash,
    input  core_done
  );

  modport slave (
    input  core_rst_n,
    input  core_start,
    output core_addr,
    output core_rq,
    input  core_rdy,
    input  core_data,
    output core_hash,
    output core_done
  );
endinterface

// File: rtl/sha256d_nonce_scanner.sv
// Nonce-search controller: holds header/target, feeds one double-SHA256 core per candidate nonce,
// and stops on a hash at or below target, on range exhaustion, or on abort.
module sha256d_nonce_scanner #(
  parameter logic [31:0] NONCE_STEP  = 32'd1,
  parameter bit          TARGET_SWAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [4:0]   cfg_addr,
  input  logic [31:0]  cfg_wdata,
  input  logic         go,
  input  logic         abort,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic [31:0]  nonce_out,
  output logic [255:0] hash_out,
  output logic [31:0]  hashes,
  sha256d_nonce_scanner_if.master core
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_LAUNCH,
    S_RUN,
    S_CHECK,
    S_ABORT
  } state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i*8 +: 8] = v[(31-i)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic          found_q, found_d;
  logic          exhausted_q, exhausted_d;
  logic          core_rst_n_q, core_rst_n_d;
  logic [31:0]   nonce_q, nonce_d;
  logic [31:0]   nonce_out_q, nonce_out_d;
  logic [255:0]  hash_out_q, hash_out_d;
  logic [31:0]   hashes_q, hashes_d;
  logic [31:0]   header_q [0:18];
  logic [31:0]   header_d [0:18];
  logic [31:0]   nonce_start_q, nonce_start_d;
  logic [31:0]   nonce_end_q, nonce_end_d;
  logic [31:0]   target_q [0:7];
  logic [31:0]   target_d [0:7];

  logic [255:0]  target_val;
  logic [255:0]  cmp_val;
  logic [31:0]   remain;
  logic          hit;
  logic          last_attempt;
  logic          abort_act;
  logic [2:0]    tgt_idx;
  logic [31:0]   core_data_c;

  // Target register 21 holds the most significant word of the 256-bit compare value.
  always_comb begin
    target_val = '0;
    for (int i = 0; i < 8; i++) begin
      target_val[255-32*i -: 32] = target_q[i];
    end
  end

  always_comb begin
    if (TARGET_SWAP) begin
      cmp_val = bswap256(hash_out_q);
    end else begin
      cmp_val = hash_out_q;
    end
    hit          = (cmp_val <= target_val);
    remain       = nonce_end_q - nonce_q;
    last_attempt = (remain < NONCE_STEP);
    abort_act    = abort && (state_q != S_IDLE) && (state_q != S_ABORT);
  end

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    found_d       = found_q;
    exhausted_d   = exhausted_q;
    nonce_d       = nonce_q;
    nonce_out_d   = nonce_out_q;
    hash_out_d    = hash_out_q;
    hashes_d      = hashes_q;
    header_d      = header_q;
    nonce_start_d = nonce_start_q;
    nonce_end_d   = nonce_end_q;
    target_d      = target_q;
    tgt_idx       = 3'(cfg_addr - 5'd21);

    // Configuration is frozen for the whole scan so every attempt hashes the same header/target.
    if (cfg_we && !busy_q) begin
      if (cfg_addr < 5'd19) begin
        header_d[cfg_addr] = cfg_wdata;
      end else if (cfg_addr == 5'd19) begin
        nonce_start_d = cfg_wdata;
      end else if (cfg_addr == 5'd20) begin
        nonce_end_d = cfg_wdata;
      end else if (cfg_addr <= 5'd28) begin
        target_d[tgt_idx] = cfg_wdata;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          found_d     = 1'b0;
          exhausted_d = 1'b0;
          hashes_d    = '0;
          nonce_d     = nonce_start_q;
          busy_d      = 1'b1;
          state_d     = S_PREP;
        end
      end
      S_PREP: begin
        state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (core.core_done) begin
          hash_out_d  = core.core_hash;
          nonce_out_d = nonce_q;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        hashes_d = sat_inc32(hashes_q);
        if (hit) begin
          found_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (last_attempt) begin
          exhausted_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          nonce_d = nonce_q + NONCE_STEP;
          state_d = S_PREP;
        end
      end
      S_ABORT: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a hit being judged in CHECK.
    if (abort_act) begin
      state_d     = S_ABORT;
      busy_d      = 1'b1;
      found_d     = found_q;
      exhausted_d = exhausted_q;
      nonce_d     = nonce_q;
      nonce_out_d = nonce_out_q;
      hash_out_d  = hash_out_q;
      hashes_d    = hashes_q;
    end

    core_rst_n_d = !((state_d == S_PREP) || (state_d == S_ABORT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      core_rst_n_q  <= 1'b0;
      nonce_q       <= '0;
      nonce_out_q   <= '0;
      hash_out_q    <= '0;
      hashes_q      <= '0;
      nonce_start_q <= '0;
      nonce_end_q   <= '0;
      for (int i = 0; i < 19; i++) begin
        header_q[i] <= '0;
      end
      for (int i = 0; i < 8; i++) begin
        target_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      core_rst_n_q  <= core_rst_n_d;
      nonce_q       <= nonce_d;
      nonce_out_q   <= nonce_out_d;
      hash_out_q    <= hash_out_d;
      hashes_q      <= hashes_d;
      nonce_start_q <= nonce_start_d;
      nonce_end_q   <= nonce_end_d;
      header_q      <= header_d;
      target_q      <= target_d;
    end
  end

  // Word 19 is the nonce, presented little-endian as it sits in the serialized header.
  always_comb begin
    core_data_c = '0;
    if (state_q == S_RUN) begin
      if (core.core_addr < 5'd19) begin
        core_data_c = header_q[core.core_addr];
      end else if (core.core_addr == 5'd19) begin
        core_data_c = bswap32(nonce_q);
      end
    end
  end

  assign core.core_data  = core_data_c;
  assign core.core_rdy   = core.core_rq && (state_q == S_RUN);
  assign core.core_start = (state_q == S_LAUNCH);
  assign core.core_rst_n = core_rst_n_q;

  assign busy      = busy_q;
  assign found     = found_q;
  assign exhausted = exhausted_q;
  assign nonce_out = nonce_out_q;
  assign hash_out  = hash_out_q;
  assign hashes    = hashes_q;

endmodule

// File: tb/tb_sha256d_nonce_scanner.sv
// Bench for sha256d_nonce_scanner: two scanners (step 1 and step 2), each driving a behavioural
// double-SHA256 core that fetches the 20 header words and hashes them.
module tb_sha256d_nonce_scanner;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [0:18][31:0] GEN_HDR = {
    32'h01000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
    32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [255:0] sha256d_hdr(input logic [639:0] hdr);
    logic [255:0] h1;
    h1 = sha_compress(IV, hdr[639:128]);
    h1 = sha_compress(h1, {hdr[127:0], 32'h80000000, 288'h0, 64'd640});
    return sha_compress(IV, {h1, 32'h80000000, 160'h0, 64'd256});
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = v[(31-i)*8 +: 8];
    return r;
  endfunction

  typedef struct {
    string       tag;
    bit          found;
    bit          exh;
    logic [31:0] nonce;
    logic [31:0] hashes;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we = 1'b0;
  logic [4:0]   cfg_addr = '0;
  logic [31:0]  cfg_wdata = '0;
  logic         abort = 1'b0;
  logic [1:0]   go_v = '0;
  logic [1:0]   busy_v, found_v, exh_v;
  logic [31:0]  nonce_v [2];
  logic [31:0]  hashes_v [2];
  logic [255:0] hash_v [2];
  int           errors = 0;
  int           checks = 0;
  exp_t         sb [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : lane
    sha256d_nonce_scanner_if bus ();

    sha256d_nonce_scanner #(
      .NONCE_STEP  ((g == 0) ? 32'd1 : 32'd2),
      .TARGET_SWAP (1'b1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .go        (go_v[g]),
      .abort     (abort),
      .busy      (busy_v[g]),
      .found     (found_v[g]),
      .exhausted (exh_v[g]),
      .nonce_out (nonce_v[g]),
      .hash_out  (hash_v[g]),
      .hashes    (hashes_v[g]),
      .core      (bus)
    );

    logic [31:0] m_words [0:19];
    int          m_state = 0;
    int          m_idx = 0;
    int          m_wait = 0;
    int          prep_cnt = 0;

    always @(posedge clk) begin
      if (rst_n && !bus.core_rst_n) prep_cnt++;
    end

    // Core model: fetch words 0..19 one per accepted request, wait, then hold done until core reset.
    always @(posedge clk) begin : mdl
      logic [639:0] hv;
      if (!rst_n || !bus.core_rst_n) begin
        m_state       <= 0;
        m_idx         <= 0;
        bus.core_rq   <= 1'b0;
        bus.core_addr <= '0;
        bus.core_done <= 1'b0;
        bus.core_hash <= '0;
      end else begin
        case (m_state)
          0: if (bus.core_start) begin
            m_state       <= 1;
            m_idx         <= 0;
            bus.core_rq   <= 1'b1;
            bus.core_addr <= '0;
          end
          1: if (bus.core_rdy) begin
            m_words[m_idx] <= bus.core_data;
            if (m_idx == 19) begin
              bus.core_rq <= 1'b0;
              m_wait      <= 3;
              m_state     <= 2;
            end else begin
              m_idx         <= m_idx + 1;
              bus.core_addr <= 5'(m_idx + 1);
            end
          end
          2: if (m_wait == 0) begin
            for (int i = 0; i < 20; i++) hv[639-32*i -: 32] = m_words[i];
            bus.core_hash <= sha256d_hdr(hv);
            bus.core_done <= 1'b1;
            m_state       <= 3;
          end else begin
            m_wait <= m_wait - 1;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic set_target(input logic [255:0] t);
    for (int i = 0; i < 8; i++) wr(5'(21 + i), t[255-32*i -: 32]);
  endtask

  task automatic run_scan(input int sel, input string tag, input bit e_found, input bit e_exh,
                          input logic [31:0] e_nonce, input logic [31:0] e_hashes, input bit with_abort);
    exp_t e;
    exp_t got;
    int   n;
    e.tag = tag; e.found = e_found; e.exh = e_exh; e.nonce = e_nonce; e.hashes = e_hashes;
    sb.push_back(e);
    go_v[sel] = 1'b1; abort = with_abort;
    @(negedge clk);
    go_v[sel] = 1'b0; abort = 1'b0;
    check({tag, "_busy"}, busy_v[sel], 1'b1);
    n = 0;
    while (busy_v[sel] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, n < 5000, 1'b1);
    got = sb.pop_front();
    check({got.tag, "_found"}, found_v[sel], got.found);
    check({got.tag, "_exhausted"}, exh_v[sel], got.exh);
    check({got.tag, "_nonce_out"}, nonce_v[sel], got.nonce);
    check({got.tag, "_hashes"}, hashes_v[sel], got.hashes);
  endtask

  task automatic wait_launch(input string tag);
    int n;
    n = 0;
    while (!lane[0].bus.core_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_launch_seen"}, n < 100, 1'b1);
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_v[0], 1'b0);
    check("rst_found", found_v[0], 1'b0);
    check("rst_exhausted", exh_v[0], 1'b0);
    check("rst_hashes", hashes_v[0], 32'd0);
    check("rst_core_rst_n_low", lane[0].bus.core_rst_n, 1'b0);
    check("rst_core_start", lane[0].bus.core_start, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_core_rst_n_rel", lane[0].bus.core_rst_n, 1'b1);

    set_target({8{32'hFFFFFFFF}});
    wr(5'd19, 32'h12345678);
    wr(5'd20, 32'h12345678);
    run_scan(0, "single", 1'b1, 1'b0, 32'h12345678, 32'd1, 1'b0);
    check("single_word19", lane[0].m_words[19], 32'h78563412);

    set_target('0);
    wr(5'd19, 32'd5);
    wr(5'd20, 32'd7);
    p0 = lane[0].prep_cnt;
    run_scan(0, "range", 1'b0, 1'b1, 32'd7, 32'd3, 1'b0);
    check("range_prep_pulses", lane[0].prep_cnt - p0, 3);

    for (int i = 0; i < 19; i++) wr(5'(i), GEN_HDR[i]);
    set_target({32'h00000000, 32'hFFFF0000, 192'h0});
    wr(5'd19, 32'h7C2BAC1C);
    wr(5'd20, 32'h7C2BAC1E);
    run_scan(0, "genesis", 1'b1, 1'b0, 32'h7C2BAC1D, 32'd2, 1'b0);
    check("genesis_hash_le", bswap256(hash_v[0]),
          256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f);

    set_target('0);
    wr(5'd19, 32'hFFFFFFFF);
    wr(5'd20, 32'h00000001);
    run_scan(0, "wrap", 1'b0, 1'b1, 32'h00000001, 32'd3, 1'b0);

    wr(5'd19, 32'd0);
    wr(5'd20, 32'd5);
    run_scan(1, "step2", 1'b0, 1'b1, 32'd4, 32'd3, 1'b0);

    wr(5'd19, 32'h500);
    wr(5'd20, 32'h500);
    run_scan(0, "go_abort_idle", 1'b0, 1'b1, 32'h500, 32'd1, 1'b1);

    // Abort about ten cycles into RUN, with a target write and a second go attempted mid-scan.
    wr(5'd19, 32'h100);
    wr(5'd20, 32'h1FF);
    go_v[0] = 1'b1;
    @(negedge clk);
    go_v[0] = 1'b0;
    wait_launch("abort");
    cfg_we = 1'b1; cfg_addr = 5'd21; cfg_wdata = 32'hFFFFFFFF; go_v[0] = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; go_v[0] = 1'b0;
    repeat (9) @(negedge clk);
    p0 = lane[0].prep_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_v[0], 1'b0);
    @(negedge clk);
    check("abort_prep_pulse", lane[0].prep_cnt - p0, 1);
    check("abort_found", found_v[0], 1'b0);
    check("abort_exhausted", exh_v[0], 1'b0);
    check("abort_hashes", hashes_v[0], 32'd0);
    check("abort_nonce_out_kept", nonce_v[0], 32'h500);
    wr(5'd19, 32'h600);
    wr(5'd20, 32'h600);
    run_scan(0, "target_unchanged", 1'b0, 1'b1, 32'h600, 32'd1, 1'b0);

    wr(5'd19, 32'h100);
    wr(5'd20, 32'h200);
    go_v[0] = 1'b1;
    @(negedge clk);
    go_v[0] = 1'b0;
    wait_launch("midrun_rst");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", busy_v[0], 1'b0);
    check("midrun_rst_found", found_v[0], 1'b0);
    check("midrun_rst_exhausted", exh_v[0], 1'b0);
    check("midrun_rst_core_start", lane[0].bus.core_start, 1'b0);
    check("midrun_rst_core_rst_n", lane[0].bus.core_rst_n, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrun_rel_core_rst_n", lane[0].bus.core_rst_n, 1'b1);
    wr(5'd19, 32'h40);
    wr(5'd20, 32'h41);
    run_scan(0, "post_reset", 1'b0, 1'b1, 32'h41, 32'd2, 1'b0);
    check("post_reset_word19", lane[0].m_words[19], 32'h41000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
